// File: rtl/conv_window_mac.sv
// Convolution window multiply-accumulate: one output pixel per valid window, 3-cycle latency.
// Coefficients load serially into a shadow bank and commit to the active bank when complete.
module conv_window_mac #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned KERNEL_ROW_SIZE    = 3,
  parameter int unsigned KERNEL_COLUMN_SIZE = 3,
  parameter int unsigned COEF_WIDTH         = 8,
  parameter int unsigned OUT_WIDTH          = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic [KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE*DATA_WIDTH-1:0] in_matrix,
  input  logic                                                     valid_in,
  input  logic [COEF_WIDTH-1:0]                                    coef_in,
  input  logic                                                     coef_valid,
  input  logic [4:0]                                               shift_amt,
  input  logic                                                     relu_en,
  output logic [OUT_WIDTH-1:0]                                     out_point,
  output logic                                                     valid_out,
  output logic                                                     kernel_loaded,
  output logic                                                     sat_flag,
  output logic                                                     drop_flag
);

  localparam int unsigned N     = KERNEL_ROW_SIZE * KERNEL_COLUMN_SIZE;
  localparam int unsigned PW    = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int unsigned SW    = PW + $clog2(N);
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  logic signed [COEF_WIDTH-1:0] shadow_q [N];
  logic signed [COEF_WIDTH-1:0] shadow_d [N];
  logic signed [COEF_WIDTH-1:0] active_q [N];
  logic signed [COEF_WIDTH-1:0] active_d [N];
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         loaded_q, loaded_d;
  logic                         drop_q, drop_d;

  logic signed [PW-1:0]         prod_q [N];
  logic signed [PW-1:0]         prod_d [N];
  logic signed [SW-1:0]         row_q [KERNEL_ROW_SIZE];
  logic signed [SW-1:0]         row_d [KERNEL_ROW_SIZE];
  logic                         v1_q, v2_q;

  logic signed [SW-1:0]         total_c;
  logic signed [SW-1:0]         shifted_c;
  logic [OUT_WIDTH-1:0]         out_q, out_d;
  logic                         vout_q;
  logic                         sat_q, sat_d;
  logic                         accept_c;

  assign accept_c = valid_in & loaded_q;

  // Coefficient loader: the active bank only changes when the final index is written.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    drop_d   = drop_q | (valid_in & ~loaded_q);
    if (coef_valid) begin
      shadow_d[cnt_q] = coef_in;
      if (cnt_q == CNT_W'(N - 1)) begin
        active_d = shadow_d;
        cnt_d    = '0;
        loaded_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1 products: pixels are unsigned, so widen with a zero MSB before the signed multiply.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      prod_d[i] = PW'($signed({1'b0, in_matrix[i*DATA_WIDTH +: DATA_WIDTH]})) * PW'(active_q[i]);
    end
  end

  always_comb begin
    for (int r = 0; r < int'(KERNEL_ROW_SIZE); r++) begin
      row_d[r] = '0;
      for (int c = 0; c < int'(KERNEL_COLUMN_SIZE); c++) begin
        row_d[r] = row_d[r] + SW'(prod_q[r*KERNEL_COLUMN_SIZE + c]);
      end
    end
  end

  // Stage 3: total, floor shift, optional ReLU, then clamp into the unsigned output range.
  always_comb begin
    total_c = '0;
    for (int r = 0; r < int'(KERNEL_ROW_SIZE); r++) begin
      total_c = total_c + row_q[r];
    end
    shifted_c = total_c >>> shift_amt;
    out_d     = out_q;
    sat_d     = sat_q;
    if (v2_q) begin
      if (shifted_c[SW-1]) begin
        out_d = '0;
        if (!relu_en) sat_d = 1'b1;
      end else if (|shifted_c[SW-1:OUT_WIDTH]) begin
        out_d = '1;
        sat_d = 1'b1;
      end else begin
        out_d = shifted_c[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        prod_q[i]   <= '0;
      end
      for (int r = 0; r < int'(KERNEL_ROW_SIZE); r++) begin
        row_q[r] <= '0;
      end
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      drop_q   <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      out_q    <= '0;
      vout_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      drop_q   <= drop_d;
      v1_q     <= accept_c;
      v2_q     <= v1_q;
      if (accept_c) prod_q <= prod_d;
      if (v1_q) row_q <= row_d;
      out_q    <= out_d;
      vout_q   <= v2_q;
      sat_q    <= sat_d;
    end
  end

  assign out_point     = out_q;
  assign valid_out     = vout_q;
  assign kernel_loaded = loaded_q;
  assign sat_flag      = sat_q;
  assign drop_flag     = drop_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac with default parameters (3x3 window, 8-bit data/coef/out).
module tb_conv_window_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] in_matrix;
  logic        valid_in;
  logic [7:0]  coef_in;
  logic        coef_valid;
  logic [4:0]  shift_amt;
  logic        relu_en;
  logic [7:0]  out_point;
  logic        valid_out;
  logic        kernel_loaded;
  logic        sat_flag;
  logic        drop_flag;

  int n_assert = 0;
  int n_fail   = 0;

  conv_window_mac dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_matrix     (in_matrix),
    .valid_in      (valid_in),
    .coef_in       (coef_in),
    .coef_valid    (coef_valid),
    .shift_amt     (shift_amt),
    .relu_en       (relu_en),
    .out_point     (out_point),
    .valid_out     (valid_out),
    .kernel_loaded (kernel_loaded),
    .sat_flag      (sat_flag),
    .drop_flag     (drop_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    valid_in   = 1'b0;
    coef_valid = 1'b0;
    coef_in    = '0;
    rst_n      = 1'b0;
    #3;
    rst_n      = 1'b1;
  endtask

  task automatic load_kernel(input logic [71:0] k);
    for (int i = 0; i < 9; i++) begin
      coef_in    = k[i*8 +: 8];
      coef_valid = 1'b1;
      tick();
    end
    coef_valid = 1'b0;
  endtask

  function automatic logic [71:0] kern_const(input logic [7:0] v);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [71:0] win_mix(input int c);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(c*37 + i*29 + i*i*c);
    return w;
  endfunction

  // Behavioural reference: integer MAC, floor shift, ReLU, clamp to [0,255].
  function automatic void model(input logic [71:0] pix, input logic [71:0] k, input int sh,
                                input bit relu, output int o, output bit s);
    longint sum;
    logic signed [7:0] cf;
    logic [7:0] px;
    sum = 0;
    for (int i = 0; i < 9; i++) begin
      cf  = k[i*8 +: 8];
      px  = pix[i*8 +: 8];
      sum = sum + longint'(cf) * longint'(px);
    end
    sum = sum >>> sh;
    if (relu && sum < 0) sum = 0;
    s = 1'b0;
    if (sum < 0) begin
      o = 0; s = 1'b1;
    end else if (sum > 255) begin
      o = 255; s = 1'b1;
    end else begin
      o = int'(sum);
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] kern;
    logic [71:0] ramp;
    bit          pat [14];
    int          exp_o [14];
    bit          exp_s;
    bit          s_tmp;
    int          o_tmp;

    in_matrix = '0;
    shift_amt = '0;
    relu_en   = 1'b0;
    do_reset();
    check("reset_out", 32'(out_point), 0);
    check("reset_valid", 32'(valid_out), 0);
    check("reset_loaded", 32'(kernel_loaded), 0);
    check("reset_sat", 32'(sat_flag), 0);
    check("reset_drop", 32'(drop_flag), 0);

    // Identity kernel: centre tap selects element 4 (value 5).
    kern = '0;
    kern[4*8 +: 8] = 8'd1;
    load_kernel(kern);
    check("id_loaded", 32'(kernel_loaded), 1);
    for (int i = 0; i < 9; i++) ramp[i*8 +: 8] = 8'(i + 1);
    in_matrix = ramp;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    check("id_lat_e1", 32'(valid_out), 0);
    tick();
    check("id_lat_e2", 32'(valid_out), 0);
    tick();
    check("id_valid", 32'(valid_out), 1);
    check("id_out", 32'(out_point), 5);
    tick();
    check("id_valid_drop", 32'(valid_out), 0);
    check("id_out_hold", 32'(out_point), 5);
    check("id_sat", 32'(sat_flag), 0);

    // Saturation high: 9*255 = 2295.
    do_reset();
    load_kernel(kern_const(8'd1));
    in_matrix = kern_const(8'd255);
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    tick(); tick();
    check("sat_valid", 32'(valid_out), 1);
    check("sat_out", 32'(out_point), 255);
    check("sat_flag", 32'(sat_flag), 1);

    do_reset();
    check("sat_flag_cleared", 32'(sat_flag), 0);
    load_kernel(kern_const(8'd1));
    shift_amt = 5'd4;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    tick(); tick();
    check("shift4_out", 32'(out_point), 143);
    check("shift4_sat", 32'(sat_flag), 0);

    // Negative sums: -90 with and without ReLU.
    do_reset();
    shift_amt = '0;
    relu_en   = 1'b1;
    load_kernel(kern_const(8'hFF));
    in_matrix = kern_const(8'd10);
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    tick(); tick();
    check("relu_valid", 32'(valid_out), 1);
    check("relu_out", 32'(out_point), 0);
    check("relu_sat", 32'(sat_flag), 0);
    relu_en  = 1'b0;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick();
    check("neg_out", 32'(out_point), 0);
    check("neg_sat", 32'(sat_flag), 1);

    // Streaming 6 windows, one-cycle gap, 2 more, against the reference model.
    do_reset();
    for (int i = 0; i < 9; i++) kern[i*8 +: 8] = 8'(((i*5) % 9) - 4);
    load_kernel(kern);
    shift_amt = 5'd2;
    relu_en   = 1'b0;
    exp_s     = 1'b0;
    for (int c = 0; c < 14; c++) pat[c] = (c < 6) || (c == 7) || (c == 8);
    for (int c = 0; c < 14; c++) begin
      in_matrix = win_mix(c);
      valid_in  = pat[c];
      model(win_mix(c), kern, 2, 1'b0, o_tmp, s_tmp);
      exp_o[c] = o_tmp;
      if (pat[c]) exp_s = exp_s | s_tmp;
      tick();
      if (c >= 2) begin
        check($sformatf("stream_valid_%0d", c), 32'(valid_out), 32'(pat[c-2]));
        if (pat[c-2]) check($sformatf("stream_out_%0d", c), 32'(out_point), 32'(exp_o[c-2]));
      end
    end
    valid_in = 1'b0;
    check("stream_sat", 32'(sat_flag), 32'(exp_s));

    // Windows before any kernel are dropped.
    do_reset();
    shift_amt = '0;
    in_matrix = kern_const(8'd1);
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("drop_novalid_%0d", c), 32'(valid_out), 0);
      tick();
    end
    check("drop_flag", 32'(drop_flag), 1);

    // Reload mid-stream: windows accepted through the commit edge see the old kernel (sum 9).
    load_kernel(kern_const(8'd1));
    in_matrix = kern_const(8'd1);
    for (int c = 0; c < 13; c++) begin
      valid_in   = 1'b1;
      coef_valid = (c < 9);
      coef_in    = 8'd2;
      tick();
      if (c >= 2) begin
        check($sformatf("reload_valid_%0d", c), 32'(valid_out), 1);
        check($sformatf("reload_out_%0d", c), 32'(out_point), (c - 2 <= 8) ? 9 : 18);
      end
    end
    coef_valid = 1'b0;
    check("reload_loaded", 32'(kernel_loaded), 1);
    check("reload_drop_sticky", 32'(drop_flag), 1);

    // Asynchronous reset with windows still in flight.
    tick();
    check("mid_valid_before", 32'(valid_out), 1);
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(valid_out), 0);
    check("mid_async_out", 32'(out_point), 0);
    check("mid_async_loaded", 32'(kernel_loaded), 0);
    check("mid_async_drop", 32'(drop_flag), 0);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mid_nostale_%0d", c), 32'(valid_out), 0);
    end
    check("mid_loaded_after", 32'(kernel_loaded), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Downstream consumer of conv_buffer. Takes each KERNEL_ROW_SIZE x KERNEL_COLUMN_SIZE pixel window plus its valid strobe and produces one convolved output pixel per window.
- Pipeline: multiply-accumulate against a runtime-loaded signed kernel, then arithmetic right shift, optional ReLU, and saturation to an unsigned output pixel.
- Fully pipelined at one window per clock, 3-cycle latency, no backpressure.

Parameters:
- DATA_WIDTH, 8, unsigned input pixel width.
- KERNEL_ROW_SIZE, 3, window rows.
- KERNEL_COLUMN_SIZE, 3, window columns.
- COEF_WIDTH, 8, signed two's-complement coefficient width.
- OUT_WIDTH, 8, unsigned output pixel width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_matrix  input  KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE*DATA_WIDTH  window from conv_buffer out_matrix. Element i is at bits [i*DATA_WIDTH +: DATA_WIDTH], i = 0 at the LSB.
- valid_in  input  1  window valid; driven by conv_buffer valid_out.
- coef_in  input  COEF_WIDTH  serial coefficient load data.
- coef_valid  input  1  coefficient write strobe.
- shift_amt  input  5  right-shift applied to the accumulated sum; must be held stable while streaming.
- relu_en  input  1  clamp negative sums to 0 when 1.
- out_point  output  OUT_WIDTH  convolved pixel.
- valid_out  output  1  out_point valid, one cycle per accepted window.
- kernel_loaded  output  1  active coefficient bank holds a complete kernel.
- sat_flag  output  1  sticky; set when any output saturated high or low.
- drop_flag  output  1  sticky; set when valid_in arrived while kernel_loaded=0.

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - out_point=0, valid_out=0, kernel_loaded=0, sat_flag=0, drop_flag=0.
  - All pipeline valids cleared, both coefficient banks zeroed, load counter=0.
  - In-flight windows are discarded.
- Coefficient load:
  - N = KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE.
  - Each coef_valid cycle writes coef_in to shadow[load_cnt] and increments load_cnt; index 0 is loaded first.
  - On the cycle load_cnt==N-1 with coef_valid: the shadow bank (including this write) commits to the active bank at that edge, load_cnt wraps to 0, and kernel_loaded goes to 1.
  - Partial loads never affect the active bank. kernel_loaded stays 1 through subsequent reloads.
  - A window sampled on the same edge as the commit uses the old bank; the next window uses the new bank.
- Acceptance:
  - A window is accepted on an edge where valid_in=1 and kernel_loaded=1.
  - valid_in=1 with kernel_loaded=0 drops the window (no output) and sets drop_flag.
- Pipeline (accepted at edge t):
  - S1 (edge t): register N products p_i = $signed({1'b0,pixel_i}) * $signed(coef_i). Product width DATA_WIDTH+COEF_WIDTH+1.
  - S2 (edge t+1): register KERNEL_ROW_SIZE row sums.
  - S3 (edge t+2): compute the total sum, full width, no overflow possible.
    - Sum width = product width + clog2(N).
    - Arithmetic right shift by shift_amt, with truncation toward minus infinity.
    - If relu_en and result <0, result=0.
    - Saturate to [0, 2^OUT_WIDTH-1]; set sat_flag if clamped (a ReLU clamp to 0 does not set it).
    - Register out_point and valid_out.
  - valid_out is high for exactly the cycle following edge t+2. out_point holds its last value when valid_out=0.
- Throughput and flags:
  - Back-to-back windows produce back-to-back valid_out with no bubbles.
  - Gaps in valid_in are reproduced exactly, 3 cycles later.
  - sat_flag and drop_flag clear only on reset.
- Zero-padded edge windows from upstream are processed as ordinary data.

Test Plan:
- Identity kernel, sum path:
  - Stimulus: load kernel with coef 4=1, others 0; shift 0, relu_en=0; window elements 1..9 (element i = i+1).
  - Required: out_point=5, valid_out exactly 3 edges after acceptance; sat_flag=0.
- Saturation:
  - Stimulus: all-ones kernel, all pixels 255, shift_amt=0.
  - Required: out_point=255, sat_flag=1.
  - Same window with shift_amt=4 after reset and reload: out_point=143 (2295>>4).
- Negative sums:
  - Stimulus: all coefficients -1, all pixels 10, relu_en=1.
  - Required: out_point=0, sat_flag=0.
  - With relu_en=0: out_point=0 and sat_flag=1 (-90 clamped).
- Streaming with a gap:
  - Stimulus: 6 consecutive windows, a one-cycle gap, then 2 more.
  - Required: valid_out pattern 111111 0 11, offset by 3 cycles; values match a reference model.
- Drop before load, then reload mid-stream:
  - Stimulus: valid_in before any kernel load.
  - Required: no valid_out, drop_flag=1.
  - Stimulus: stream windows while loading a new kernel.
  - Required: windows accepted at or before the commit edge use the old kernel; later windows use the new kernel.
- Mid-stream reset:
  - Stimulus: assert rst_n=0 with 2 windows in flight.
  - Required: valid_out=0 immediately (async), no stale outputs after release, kernel_loaded=0.
